// File: rtl/tx_scheduler_pkg.sv
// tx_scheduler_pkg: shared types and constants for the UART transmit scheduler.
// Rev 1.0
`default_nettype none

package tx_scheduler_pkg;

  localparam int UART_DATA_BIT = 8;
  localparam logic [UART_DATA_BIT-1:0] ACK_HEADER_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Byte index: 0..2 walk the ack frame, 3 marks the single echo byte.
  localparam logic [1:0] IDX_ACK_FIRST = 2'd0;
  localparam logic [1:0] IDX_ACK_LAST  = 2'd2;
  localparam logic [1:0] IDX_ECHO      = 2'd3;

  function automatic logic [UART_DATA_BIT-1:0] ack_byte(
    input logic [1:0]               idx,
    input logic [UART_DATA_BIT-1:0] header,
    input logic [UART_DATA_BIT-1:0] cmd
  );
    case (idx)
      2'd0:    ack_byte = header;
      2'd1:    ack_byte = cmd;
      default: ack_byte = header ^ cmd;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/tx_scheduler_req_slot.sv
// req_slot: one-deep pending request slot with overrun detection.
// Rev 1.0
`default_nettype none

module req_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [WIDTH-1:0] req_data,
  input  logic             clr,
  output logic             full,
  output logic [WIDTH-1:0] data,
  output logic             ovr
);

  // A request landing on the clearing cycle refills the slot instead of overrunning.
  logic accept;
  assign accept = req & (~full | clr);
  assign ovr    = req & full & ~clr & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else begin
      if (accept) begin
        full <= 1'b1;
        data <= req_data;
      end else if (clr) begin
        full <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tx_scheduler.sv
// tx_scheduler: arbitrates one UART transmitter between echo bytes and 3-byte ack frames.
// Rev 1.0
`default_nettype none

module tx_scheduler
  import tx_scheduler_pkg::*;
#(
  parameter bit                       ECHO_EN    = 1'b1,
  parameter logic [UART_DATA_BIT-1:0] ACK_HEADER = ACK_HEADER_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [UART_DATA_BIT-1:0] rx_data_i,
  input  logic                     rx_done_tick_i,
  input  logic [UART_DATA_BIT-1:0] cmd_i,
  input  logic                     done_tick_i,
  output logic                     tx_start_o,
  output logic [UART_DATA_BIT-1:0] tx_data_o,
  input  logic                     tx_done_tick_i,
  output logic                     busy_o,
  output logic                     echo_ovr_o,
  output logic                     ack_ovr_o
);

  state_t state, state_next;
  logic [1:0] idx, idx_next;

  logic                     echo_req, echo_full, echo_clr;
  logic [UART_DATA_BIT-1:0] echo_data;
  logic                     ack_full, ack_clr;
  logic [UART_DATA_BIT-1:0] ack_data;

  assign echo_req = rx_done_tick_i & ECHO_EN;

  req_slot #(.WIDTH(UART_DATA_BIT)) u_echo_slot (
    .clk      (clk_i),
    .rst      (rst_i),
    .req      (echo_req),
    .req_data (rx_data_i),
    .clr      (echo_clr),
    .full     (echo_full),
    .data     (echo_data),
    .ovr      (echo_ovr_o)
  );

  req_slot #(.WIDTH(UART_DATA_BIT)) u_ack_slot (
    .clk      (clk_i),
    .rst      (rst_i),
    .req      (done_tick_i),
    .req_data (cmd_i),
    .clr      (ack_clr),
    .full     (ack_full),
    .data     (ack_data),
    .ovr      (ack_ovr_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      idx   <= IDX_ACK_FIRST;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    ack_clr    = 1'b0;
    echo_clr   = 1'b0;
    tx_start_o = 1'b0;
    busy_o     = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (ack_full) begin
          state_next = ST_START;
          idx_next   = IDX_ACK_FIRST;
        end else if (echo_full) begin
          state_next = ST_START;
          idx_next   = IDX_ECHO;
        end
      end
      ST_START: begin
        tx_start_o = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done_tick_i) begin
          if (idx == IDX_ECHO) begin
            echo_clr   = 1'b1;
            state_next = ST_IDLE;
          end else if (idx == IDX_ACK_LAST) begin
            ack_clr    = 1'b1;
            state_next = ST_IDLE;
          end else begin
            idx_next   = idx + 2'd1;
            state_next = ST_START;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Slot data cannot change while its request is being sent, so the byte is muxed live.
  assign tx_data_o = (state == ST_IDLE) ? '0 :
                     (idx == IDX_ECHO)  ? echo_data :
                                          ack_byte(idx, ACK_HEADER, ack_data);

endmodule

`default_nettype wire

// File: tb/tb_tx_scheduler.sv
// tb_tx_scheduler: randomized + directed bench for tx_scheduler against a queue-based model.
// Rev 1.0
`default_nettype none

module tb_tx_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_tick = 1'b0;
  logic [7:0] cmd = 8'h00;
  logic       done_tick = 1'b0;
  logic       resp_done = 1'b0;
  logic       man_done = 1'b0;
  logic       tx_done;
  logic       tx_start, busy, echo_ovr, ack_ovr;
  logic [7:0] tx_data;
  logic       start0, busy0, eovr0, aovr0;
  logic [7:0] data0;

  assign tx_done = resp_done | man_done;

  tx_scheduler dut (
    .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_done_tick_i(rx_tick),
    .cmd_i(cmd), .done_tick_i(done_tick), .tx_start_o(tx_start), .tx_data_o(tx_data),
    .tx_done_tick_i(tx_done), .busy_o(busy), .echo_ovr_o(echo_ovr), .ack_ovr_o(ack_ovr)
  );

  tx_scheduler #(.ECHO_EN(1'b0)) dut_noecho (
    .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_done_tick_i(rx_tick),
    .cmd_i(cmd), .done_tick_i(done_tick), .tx_start_o(start0), .tx_data_o(data0),
    .tx_done_tick_i(tx_done), .busy_o(busy0), .echo_ovr_o(eovr0), .ack_ovr_o(aovr0)
  );

  initial forever #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;
  bit chk_noecho = 1'b0;
  bit auto_resp = 1'b1;
  bit rand_delay = 1'b0;
  int resp_delay = 3;
  int eovr_cnt = 0;
  int aovr_cnt = 0;
  logic [7:0] dlog[$];

  // Reference model: pending requests plus the byte list of the job on the wire.
  bit         m_ack_p, m_echo_p, m_active, m_start, m_kind_ack;
  logic [7:0] m_ack_d, m_echo_d, m_cur;
  logic [7:0] m_rest[$];

  function automatic bit m_clearing(input bit ack_kind);
    return !rst && m_active && !m_start && tx_done && (m_rest.size() == 0) && (m_kind_ack == ack_kind);
  endfunction

  task automatic model_step();
    bit ce, ca;
    if (rst) begin
      m_ack_p = 0; m_echo_p = 0; m_active = 0; m_start = 0;
      m_ack_d = 8'h00; m_echo_d = 8'h00; m_cur = 8'h00;
      m_rest.delete();
    end else begin
      ce = m_clearing(1'b0);
      ca = m_clearing(1'b1);
      if (m_active) begin
        if (m_start) m_start = 0;
        else if (tx_done) begin
          if (m_rest.size() == 0) m_active = 0;
          else begin m_cur = m_rest.pop_front(); m_start = 1; end
        end
      end else if (m_ack_p) begin
        m_active = 1; m_start = 1; m_kind_ack = 1;
        m_cur = 8'hA5;
        m_rest = {m_ack_d, 8'hA5 ^ m_ack_d};
      end else if (m_echo_p) begin
        m_active = 1; m_start = 1; m_kind_ack = 0;
        m_cur = m_echo_d;
        m_rest.delete();
      end
      if (rx_tick && (!m_echo_p || ce)) begin m_echo_p = 1; m_echo_d = rx_data; end
      else if (ce) m_echo_p = 0;
      if (done_tick && (!m_ack_p || ca)) begin m_ack_p = 1; m_ack_d = cmd; end
      else if (ca) m_ack_p = 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("tx_start", {7'd0, tx_start}, {7'd0, m_start});
      check("busy", {7'd0, busy}, {7'd0, m_active});
      check("tx_data", tx_data, m_active ? m_cur : 8'h00);
      check("echo_ovr", {7'd0, echo_ovr}, {7'd0, !rst && rx_tick && m_echo_p && !m_clearing(1'b0)});
      check("ack_ovr", {7'd0, ack_ovr}, {7'd0, !rst && done_tick && m_ack_p && !m_clearing(1'b1)});
      check("noecho_ovr", {7'd0, eovr0}, 8'h00);
      if (chk_noecho) begin
        check("noecho_start", {7'd0, start0}, 8'h00);
        check("noecho_busy", {7'd0, busy0}, 8'h00);
        check("noecho_data", data0, 8'h00);
        check("noecho_ackovr", {7'd0, aovr0}, 8'h00);
      end
      if (tx_start) dlog.push_back(tx_data);
      if (echo_ovr) eovr_cnt++;
      if (ack_ovr) aovr_cnt++;
    end
  end

  // Transmitter stand-in: answers each start with a done pulse after a delay.
  initial forever begin
    int d;
    @(negedge clk);
    if (tx_start && auto_resp) begin
      d = rand_delay ? int'($urandom_range(1, 6)) : resp_delay;
      repeat (d) @(posedge clk);
      #1 resp_done = 1'b1;
      @(posedge clk);
      #1 resp_done = 1'b0;
    end
  end

  task automatic drive(input bit r, input logic [7:0] rd, input bit a, input logic [7:0] c, input bit d);
    rx_tick = r; rx_data = rd; done_tick = a; cmd = c; man_done = d;
    @(posedge clk);
    #1;
    rx_tick = 0; done_tick = 0; man_done = 0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 500; i++) begin
      if (!m_active && !m_ack_p && !m_echo_p && !tx_done) begin ok = 1; break; end
      idle_cycles(1);
    end
    if (!ok) begin
      miscompares++;
      $display("FAIL wait_idle: busy=%0b still set after bound, required 0", busy);
    end
    idle_cycles(2);
  endtask

  task automatic wait_start(input int n);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (dlog.size() > n) begin ok = 1; break; end
      idle_cycles(1);
    end
    if (!ok) begin
      miscompares++;
      $display("FAIL wait_start: %0d starts seen, required more than %0d", dlog.size(), n);
    end
  endtask

  task automatic check_log(input string name, input int n, input logic [47:0] bytes);
    check({name, "_count"}, 8'(dlog.size()), 8'(n));
    for (int i = 0; i < n && i < dlog.size(); i++)
      check(name, dlog[i], bytes[8*(n-1-i) +: 8]);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1;
    rst = 0;
    check("reset_busy", {7'd0, busy}, 8'h00);
    check("reset_data", tx_data, 8'h00);

    // Single echo, also watching the ECHO_EN=0 instance stay quiet.
    chk_noecho = 1;
    dlog.delete();
    drive(1, 8'h55, 0, 8'h00, 0);
    wait_idle();
    check_log("echo", 1, 48'h55);
    chk_noecho = 0;

    resp_delay = 10;
    dlog.delete();
    drive(0, 8'h00, 1, 8'h01, 0);
    wait_idle();
    check_log("ack", 3, 48'hA5_01_A4);

    resp_delay = 2;
    dlog.delete();
    drive(1, 8'h33, 1, 8'h02, 0);
    wait_idle();
    check_log("simul", 4, 48'hA5_02_A7_33);

    // Echo overrun: 20 refills the slot on its clearing cycle, 30 is dropped.
    auto_resp = 0;
    dlog.delete();
    eovr_cnt = 0;
    drive(1, 8'h10, 0, 8'h00, 0);
    wait_start(0);
    idle_cycles(4);
    drive(1, 8'h20, 0, 8'h00, 1);
    idle_cycles(1);
    drive(1, 8'h30, 0, 8'h00, 0);
    wait_start(1);
    idle_cycles(3);
    drive(0, 8'h00, 0, 8'h00, 1);
    wait_idle();
    check_log("echo_ovr", 2, 48'h10_20);
    check("echo_ovr_pulses", 8'(eovr_cnt), 8'd1);

    // Ack overrun: 08 dropped mid-frame, 0C accepted on the clearing cycle.
    dlog.delete();
    aovr_cnt = 0;
    drive(0, 8'h00, 1, 8'h04, 0);
    wait_start(0);
    idle_cycles(2);
    drive(0, 8'h00, 1, 8'h08, 0);
    drive(0, 8'h00, 0, 8'h00, 1);
    wait_start(1);
    idle_cycles(1);
    drive(0, 8'h00, 0, 8'h00, 1);
    wait_start(2);
    idle_cycles(1);
    auto_resp = 1;
    resp_delay = 3;
    drive(0, 8'h00, 1, 8'h0C, 1);
    wait_idle();
    check_log("ack_ovr", 6, 48'hA5_04_A1_A5_0C_A9);
    check("ack_ovr_pulses", 8'(aovr_cnt), 8'd1);

    // Reset on the cycle the first frame byte completes.
    resp_delay = 5;
    dlog.delete();
    drive(0, 8'h00, 1, 8'h01, 0);
    begin
      bit seen = 0;
      for (int i = 0; i < 100; i++) begin
        @(posedge clk);
        #2;
        if (tx_done) begin seen = 1; break; end
      end
      if (!seen) begin
        miscompares++;
        $display("FAIL reset_tx_done: tx_done never seen, required 1");
      end
    end
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    idle_cycles(20);
    check_log("reset_mid", 1, 48'hA5);
    check("reset_mid_busy", {7'd0, busy}, 8'h00);
    dlog.delete();
    drive(1, 8'h77, 0, 8'h00, 0);
    wait_idle();
    check_log("post_reset", 1, 48'h77);

    // Stray transmitter tick while idle.
    dlog.delete();
    drive(0, 8'h00, 0, 8'h00, 1);
    idle_cycles(5);
    check("stray_starts", 8'(dlog.size()), 8'd0);

    // Randomized traffic with stray ticks and occasional resets.
    rand_delay = 1;
    for (int i = 0; i < 3000; i++) begin
      rx_tick   = ($urandom_range(0, 7) == 0);
      rx_data   = 8'($urandom);
      done_tick = ($urandom_range(0, 15) == 0);
      cmd       = 8'($urandom);
      man_done  = ($urandom_range(0, 49) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      @(posedge clk);
      #1;
    end
    rx_tick = 0; done_tick = 0; man_done = 0; rst = 0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tx_scheduler.md
TX_SCHEDULER -- requirements
Module: tx_scheduler

Interface
REQ-001 Parameter ECHO_EN, default 1, meaning: 1 = received bytes are echoed on the UART transmitter, 0 = echo requests are ignored.
REQ-002 Parameter ACK_HEADER, default 8'hA5, meaning: first byte of every acknowledge frame.
REQ-003 Port clk_i, input, 1, meaning: single system clock; all logic runs on its rising edge.
REQ-004 Port rst_i, input, 1, meaning: synchronous active-high reset.
REQ-005 Port rx_data_i, input, 8, meaning: byte from the UART receiver; valid while rx_done_tick_i is high.
REQ-006 Port rx_done_tick_i, input, 1, meaning: one-cycle pulse marking an echo request.
REQ-007 Port cmd_i, input, 8, meaning: command byte from the decoder; valid while done_tick_i is high.
REQ-008 Port done_tick_i, input, 1, meaning: one-cycle pulse marking an acknowledge request.
REQ-009 Port tx_start_o, output, 1, meaning: one-cycle pulse that starts the UART transmitter.
REQ-010 Port tx_data_o, output, 8, meaning: byte for the UART transmitter.
REQ-011 Port tx_done_tick_i, input, 1, meaning: transmitter has finished the current byte.
REQ-012 Port busy_o, output, 1, meaning: high whenever the FSM is not in IDLE.
REQ-013 Port echo_ovr_o, output, 1, meaning: one-cycle pulse when an echo byte is dropped.
REQ-014 Port ack_ovr_o, output, 1, meaning: one-cycle pulse when an acknowledge request is dropped.

Function
REQ-015 The block SHALL share one UART transmitter between two requesters: echo (single byte) and acknowledge (3-byte frame).
- Frame contents, in order: ACK_HEADER, cmd, ACK_HEADER XOR cmd.
REQ-016 Each requester SHALL have a 1-deep pending slot.
- Echo slot: on rx_done_tick_i with ECHO_EN=1, set the flag and capture rx_data_i.
- Ack slot: on done_tick_i, set the flag and capture cmd_i.
REQ-017 A request arriving while its slot is full SHALL be dropped.
- The original slot contents are kept.
- The matching *_ovr_o pulses in that same cycle.
REQ-018 The FSM SHALL have three states: IDLE, START, WAIT.
REQ-019 In IDLE with any slot pending, the FSM SHALL go to START.
- Ack has priority over echo.
- The byte index is loaded: 0 for ack, E for echo.
REQ-020 START SHALL assert tx_start_o for exactly one cycle, then go to WAIT.
- tx_data_o is driven from the current byte index.
- tx_data_o stays stable until leaving WAIT.
REQ-021 WAIT SHALL hold until tx_done_tick_i is seen, then:
- ack index 0 or 1: increment the index and go to START;
- ack index 2: clear the ack slot and go to IDLE;
- echo: clear the echo slot and go to IDLE.
REQ-022 Latency: a request sampled in IDLE at edge n SHALL produce tx_start_o high in the cycle after edge n+1 (2 cycles).
- No idle gap is inserted between frame bytes beyond the START cycle.
REQ-023 An ack frame, once started, SHALL complete without interleaving echo bytes.
- An echo that is pending is sent after the frame.
REQ-024 A slot being cleared and a new request of the same kind in the same cycle SHALL leave the slot set with the new data and no overrun.
REQ-025 rx_done_tick_i and done_tick_i in the same cycle SHALL both be captured.
REQ-026 tx_done_tick_i outside WAIT SHALL be ignored.
REQ-027 busy_o SHALL be high in START and WAIT.

Reset
REQ-028 With rst_i high at a clock edge, the block SHALL:
- go to IDLE;
- clear both slots and the byte index;
- drive tx_start_o=0, tx_data_o=8'h00, busy_o=0, echo_ovr_o=0, ack_ovr_o=0.
REQ-029 Reset mid-frame SHALL abandon the frame without a further tx_start_o.
- Requests in the reset cycle are discarded.

Structure
REQ-030 The shared parameter package SHALL hold:
- the state encoding (IDLE/START/WAIT);
- the ACK_HEADER default;
- the UART_DATA_BIT width.
REQ-031 The block SHALL be a single module with no sub-modules.
- The pending slot may optionally be one reusable sub-module, req_slot (flag + data register + overrun detect), instantiated twice.

Verification
REQ-032 Single echo:
- Stimulus: rx_done_tick_i with rx_data_i=8'h55.
- Response: one tx_start_o 2 cycles later with tx_data_o=8'h55; busy_o drops the cycle after tx_done_tick_i.
REQ-033 Ack frame:
- Stimulus: done_tick_i with cmd_i=8'h01; respond to each tx_start_o with tx_done_tick_i 10 cycles later.
- Response: bytes A5, 01, A4.
REQ-034 Simultaneous requests:
- Stimulus: done_tick_i (cmd 8'h02) and rx_done_tick_i (8'h33) in the same cycle.
- Response: bytes A5, 02, A7, 33.
REQ-035 Echo overrun:
- Stimulus: three echo requests 8'h10, 8'h20, 8'h30 during one long WAIT.
- Response: 10 sent, 20 buffered and sent, 30 dropped with echo_ovr_o pulsed once; ack overrun checked the same way with two done_tick_i during a frame.
REQ-036 Reset mid-frame:
- Stimulus: rst_i asserted for 1 cycle after byte A5 completes.
- Response: no further tx_start_o, all outputs at their reset values, and a subsequent echo of 8'h77 works normally.
REQ-037 Parameter and stray-tick checks:
- Stimulus: ECHO_EN=0 with an echo request.
- Response: no tx_start_o and no echo_ovr_o.
- Stimulus: tx_done_tick_i in IDLE.
- Response: ignored.
